cpu_stage_ctrl: RTL and testbench

Multi-cycle sequencing controller for the NPC core. Steps every instruction through fetch, decode, execute, optional memory access and writeback. Holds the fetch and load/store handshakes and gates the register-file and CSR write enables that the decoder produces, so architectural state changes only in writeback. Converts fetch/LSU errors and handshake timeouts into trap requests, and stops the core on `ebreak`.

---
 rtl/cpu_stage_ctrl_pkg.sv | 30 +++
 rtl/ctrl_wait_timer.sv | 32 +++
 rtl/cpu_stage_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cpu_stage_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stage_ctrl_pkg.sv
// Shared definitions for the NPC multi-cycle sequencing controller.
//   ctrl_state_e : FSM state codes, also driven out on the debug `state` port
//   Cause*       : mcause codes raised by the controller
//   dec_flags_t  : decoder flags captured in DECODE for the instruction in flight
package cpu_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6,
        StHalt   = 3'd7
    } ctrl_state_e;

    localparam logic [3:0] CauseIfuFault   = 4'd1;
    localparam logic [3:0] CauseLoadFault  = 4'd5;
    localparam logic [3:0] CauseStoreFault = 4'd7;

    typedef struct packed {
        logic       mem_ren;
        logic       mem_wen;
        logic       r_wen;
        logic       ebreak;
        logic [3:0] csr_wen;
    } dec_flags_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Handshake wait timer for the FETCH and MEM states.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : hold the count at zero (asserted whenever not waiting)
//   run      : count one cycle of waiting
//   expired  : count has reached WAIT_TIMEOUT while waiting
// The caller decides whether a response in the expiry cycle wins.
module ctrl_wait_timer #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Count is 0 in the first waiting cycle, so expiry lands in cycle WAIT_TIMEOUT+1.
    assign expired = run && (count_q == 16'(WAIT_TIMEOUT));

endmodule

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle sequencing controller: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Holds the fetch/LSU handshakes, gates decoder write enables into WB only, turns
// fetch/LSU errors and wait timeouts into trap requests and halts on ebreak.
//   ifu_req/ifu_rvalid/ifu_err/ir_en     : fetch handshake and IR load strobe
//   dec_*                                : decoder flags, sampled in DECODE
//   lsu_req/lsu_wen/lsu_done/lsu_err     : LSU handshake
//   r_wen/csr_wen/pc_en                  : writeback strobes
//   trap_en/trap_cause, halted, state    : trap request, halt flag, debug state
//   cycle_cnt/instret_cnt                : performance counters, only with CTRL_PERF_CNT_EN
module cpu_stage_ctrl
    import cpu_stage_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_rvalid,
    input  logic             ifu_err,
    output logic             ir_en,
    input  logic             dec_mem_ren,
    input  logic             dec_mem_wen,
    input  logic             dec_r_wen,
    input  logic             dec_ebreak,
    input  logic [3:0]       dec_csr_wen,
    output logic             lsu_req,
    output logic             lsu_wen,
    input  logic             lsu_done,
    input  logic             lsu_err,
    output logic             r_wen,
    output logic [3:0]       csr_wen,
    output logic             pc_en,
    output logic             trap_en,
    output logic [3:0]       trap_cause,
    output logic             halted,
    output logic [2:0]       state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    ctrl_state_e state_q, state_d;
    dec_flags_t  flags_q;
    logic [3:0]  cause_q, cause_d;
    logic        waiting;
    logic        expired;
    logic [3:0]  mem_cause;

    assign waiting   = (state_q == StFetch) || (state_q == StMem);
    assign mem_cause = flags_q.mem_wen ? CauseStoreFault : CauseLoadFault;

    ctrl_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .run    (waiting),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cause_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == StDecode) begin
                flags_q <= '{mem_ren: dec_mem_ren, mem_wen: dec_mem_wen, r_wen: dec_r_wen,
                             ebreak: dec_ebreak, csr_wen: dec_csr_wen};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        ifu_req    = 1'b0;
        ir_en      = 1'b0;
        lsu_req    = 1'b0;
        lsu_wen    = 1'b0;
        r_wen      = 1'b0;
        csr_wen    = '0;
        pc_en      = 1'b0;
        trap_en    = 1'b0;
        trap_cause = '0;
        halted     = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                ifu_req = 1'b1;
                if (ifu_err || (!ifu_rvalid && expired)) begin
                    state_d = StTrap;
                    cause_d = CauseIfuFault;
                end else if (ifu_rvalid) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (flags_q.ebreak) begin
                    state_d = StHalt;
                end else if (flags_q.mem_ren || flags_q.mem_wen) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                lsu_req = 1'b1;
                lsu_wen = flags_q.mem_wen;
                if (lsu_err || (!lsu_done && expired)) begin
                    state_d = StTrap;
                    cause_d = mem_cause;
                end else if (lsu_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                r_wen   = flags_q.r_wen;
                csr_wen = flags_q.csr_wen;
                pc_en   = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
                trap_en    = 1'b1;
                trap_cause = cause_q;
                state_d    = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (state_q == StWb) begin
                instret_cnt_q <= instret_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Self-checking bench for cpu_stage_ctrl. Each instruction is described by a few
// transaction-level choices (response cycle, error, decoder flags); the expected
// per-cycle outputs are derived from those choices and checked every cycle.
module tb_cpu_stage_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 64;

    typedef struct packed {
        logic       ifu_rvalid;
        logic       ifu_err;
        logic       mem_ren;
        logic       mem_wen;
        logic       r_wen;
        logic       ebreak;
        logic [3:0] csr_wen;
        logic       lsu_done;
        logic       lsu_err;
    } stim_t;

    typedef struct packed {
        logic [2:0] state;
        logic       ifu_req;
        logic       ir_en;
        logic       lsu_req;
        logic       lsu_wen;
        logic       r_wen;
        logic [3:0] csr_wen;
        logic       pc_en;
        logic       trap_en;
        logic [3:0] cause;
        logic       halted;
    } obs_t;

    logic          clk, rst;
    logic          ifu_req, ifu_rvalid, ifu_err, ir_en;
    logic          dec_mem_ren, dec_mem_wen, dec_r_wen, dec_ebreak;
    logic [3:0]    dec_csr_wen;
    logic          lsu_req, lsu_wen, lsu_done, lsu_err;
    logic          r_wen, pc_en, trap_en, halted;
    logic [3:0]    csr_wen, trap_cause;
    logic [2:0]    state;
`ifdef CTRL_PERF_CNT_EN
    logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

    cpu_stage_ctrl #(
        .WAIT_TIMEOUT(T),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_req    (ifu_req),
        .ifu_rvalid (ifu_rvalid),
        .ifu_err    (ifu_err),
        .ir_en      (ir_en),
        .dec_mem_ren(dec_mem_ren),
        .dec_mem_wen(dec_mem_wen),
        .dec_r_wen  (dec_r_wen),
        .dec_ebreak (dec_ebreak),
        .dec_csr_wen(dec_csr_wen),
        .lsu_req    (lsu_req),
        .lsu_wen    (lsu_wen),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .r_wen      (r_wen),
        .csr_wen    (csr_wen),
        .pc_en      (pc_en),
        .trap_en    (trap_en),
        .trap_cause (trap_cause),
        .halted     (halted),
        .state      (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       tests_run    = 0;
    int       tests_failed = 0;
    bit       chk_en       = 1'b0;
    obs_t     exp_cur;
    obs_t     log_q[$];
    longint   cyc_m = 0, ins_m = 0;
    longint   exp_cyc, exp_ins;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.state   = state;
        o.ifu_req = ifu_req;
        o.ir_en   = ir_en;
        o.lsu_req = lsu_req;
        o.lsu_wen = lsu_wen;
        o.r_wen   = r_wen;
        o.csr_wen = csr_wen;
        o.pc_en   = pc_en;
        o.trap_en = trap_en;
        o.cause   = trap_cause;
        o.halted  = halted;
        return o;
    endfunction

    // Compare process: checks DUT against the expectation for the current cycle.
    obs_t cur;
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            cur = sample();
            log_q.push_back(cur);
            check("state", 64'(cur.state), 64'(exp_cur.state));
            check("handshake", 64'({cur.ifu_req, cur.ir_en, cur.lsu_req, cur.lsu_wen}),
                  64'({exp_cur.ifu_req, exp_cur.ir_en, exp_cur.lsu_req, exp_cur.lsu_wen}));
            check("writeback", 64'({cur.r_wen, cur.csr_wen, cur.pc_en}),
                  64'({exp_cur.r_wen, exp_cur.csr_wen, exp_cur.pc_en}));
            check("trap_halt", 64'({cur.trap_en, cur.cause, cur.halted}),
                  64'({exp_cur.trap_en, exp_cur.cause, exp_cur.halted}));
`ifdef CTRL_PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, exp_cyc);
            check("instret_cnt", instret_cnt, exp_ins);
`endif
        end
    end

    task automatic apply(input stim_t s);
        ifu_rvalid  = s.ifu_rvalid;
        ifu_err     = s.ifu_err;
        dec_mem_ren = s.mem_ren;
        dec_mem_wen = s.mem_wen;
        dec_r_wen   = s.r_wen;
        dec_ebreak  = s.ebreak;
        dec_csr_wen = s.csr_wen;
        lsu_done    = s.lsu_done;
        lsu_err     = s.lsu_err;
    endtask

    function automatic stim_t noise();
        return stim_t'(14'($urandom));
    endfunction

    // One clock cycle: drive inputs, post expectation, advance to the next negedge.
    task automatic cyc(input stim_t s, input obs_t e);
        apply(s);
        exp_cur = e;
        exp_cyc = cyc_m;
        exp_ins = ins_m;
        chk_en  = 1'b1;
        @(negedge clk);
        cyc_m++;
        if (e.state == 3'd5) ins_m++;
    endtask

    task automatic idle_cycle();
        obs_t e;
        e = '0;
        cyc(noise(), e);
    endtask

    task automatic trap_cycle(input logic [3:0] c);
        obs_t e;
        e = '0;
        e.state   = 3'd6;
        e.trap_en = 1'b1;
        e.cause   = c;
        cyc(noise(), e);
    endtask

    task automatic halt_cycles(input int k);
        obs_t e;
        e = '0;
        e.state  = 3'd7;
        e.halted = 1'b1;
        for (int i = 0; i < k; i++) cyc(noise(), e);
    endtask

    // fk/mk: index of the response cycle within FETCH/MEM (beyond T means timeout).
    // both: an error response also carries rvalid/done.
    task automatic run_instr(input int fk, input bit ferr, input stim_t f, input int mk,
                             input bit merr, input bit both, input int abort_at,
                             output bit hit_halt, output bit aborted);
        stim_t n;
        obs_t  e;
        logic [3:0] mcause;
        hit_halt = 1'b0;
        aborted  = 1'b0;
        for (int i = 0; i <= int'(T); i++) begin
            n = noise();
            e = '0;
            e.state   = 3'd1;
            e.ifu_req = 1'b1;
            if (i == fk) begin
                n.ifu_err    = ferr;
                n.ifu_rvalid = ferr ? both : 1'b1;
                e.ir_en      = !ferr;
                cyc(n, e);
                if (ferr) begin
                    trap_cycle(4'd1);
                    return;
                end
                break;
            end
            n.ifu_err    = 1'b0;
            n.ifu_rvalid = 1'b0;
            cyc(n, e);
            if (i == int'(T)) begin
                trap_cycle(4'd1);
                return;
            end
        end
        n = noise();
        n.mem_ren = f.mem_ren;
        n.mem_wen = f.mem_wen;
        n.r_wen   = f.r_wen;
        n.ebreak  = f.ebreak;
        n.csr_wen = f.csr_wen;
        e = '0;
        e.state = 3'd2;
        cyc(n, e);
        e.state = 3'd3;
        cyc(noise(), e);
        if (f.ebreak) begin
            hit_halt = 1'b1;
            return;
        end
        if (f.mem_ren || f.mem_wen) begin
            mcause = f.mem_wen ? 4'd7 : 4'd5;
            for (int i = 0; i <= int'(T); i++) begin
                if (i == abort_at) begin
                    aborted = 1'b1;
                    return;
                end
                n = noise();
                e = '0;
                e.state   = 3'd4;
                e.lsu_req = 1'b1;
                e.lsu_wen = f.mem_wen;
                if (i == mk) begin
                    n.lsu_err  = merr;
                    n.lsu_done = merr ? both : 1'b1;
                    cyc(n, e);
                    if (merr) begin
                        trap_cycle(mcause);
                        return;
                    end
                    break;
                end
                n.lsu_err  = 1'b0;
                n.lsu_done = 1'b0;
                cyc(n, e);
                if (i == int'(T)) begin
                    trap_cycle(mcause);
                    return;
                end
            end
        end
        e = '0;
        e.state   = 3'd5;
        e.r_wen   = f.r_wen;
        e.csr_wen = f.csr_wen;
        e.pc_en   = 1'b1;
        cyc(noise(), e);
    endtask

    // Called at a negedge (or shortly after); asserts reset well before the next posedge.
    task automatic reset_now();
        chk_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_outputs", 64'({ifu_req, ir_en, lsu_req, lsu_wen, r_wen, csr_wen, pc_en,
                                  trap_en, trap_cause, halted}), 64'd0);
        @(negedge clk);
        check("rst_hold_state", 64'(state), 64'd0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_counters", cycle_cnt | instret_cnt, 64'd0);
`endif
        rst   = 1'b0;
        cyc_m = 0;
        ins_m = 0;
        log_q.delete();
    endtask

    function automatic int count_field(input int which);
        int c = 0;
        foreach (log_q[i]) begin
            case (which)
                0: c += int'(log_q[i].r_wen);
                1: c += int'(log_q[i].pc_en);
                2: c += int'(log_q[i].lsu_req);
                3: c += int'(log_q[i].lsu_wen);
                4: c += int'(log_q[i].ifu_req);
                5: c += int'(log_q[i].halted);
                6: c += int'(log_q[i].state == 3'd1);
                default: c += int'(log_q[i].trap_en);
            endcase
        end
        return c;
    endfunction

    function automatic logic [63:0] state_seq();
        logic [63:0] s = '0;
        foreach (log_q[i]) s = (s << 3) | 64'(log_q[i].state);
        return s;
    endfunction

    function automatic logic [3:0] last_cause();
        logic [3:0] c = 4'hf;
        foreach (log_q[i]) if (log_q[i].trap_en) c = log_q[i].cause;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        stim_t  f;
        bit     h, a;
        int     fk, mk;
`ifdef CTRL_PERF_CNT_EN
        logic [CW-1:0] c0;
`endif
        rst = 1'b1;
        apply('0);
        repeat (2) @(negedge clk);
        reset_now();

        // ALU instruction, response in first FETCH cycle.
        idle_cycle();
        f = '0;
        f.r_wen = 1'b1;
        run_instr(0, 0, f, 0, 0, 0, -1, h, a);
        check("alu_seq", state_seq(), 64'o01235);
        check("alu_next_state", 64'(state), 64'd1);
        check("alu_r_wen_cycles", 64'(count_field(0)), 64'd1);
`ifdef CTRL_PERF_CNT_EN
        check("alu_instret", instret_cnt, 64'd1);
`endif

        // Load, lsu_done in the third MEM cycle.
        log_q.delete();
        f = '0;
        f.mem_ren = 1'b1;
        f.r_wen   = 1'b1;
        run_instr(0, 0, f, 2, 0, 0, -1, h, a);
        check("load_lsu_req_cycles", 64'(count_field(2)), 64'd3);
        check("load_lsu_wen_cycles", 64'(count_field(3)), 64'd0);
        check("load_seq", state_seq(), 64'o1234445);

        // Store error together with lsu_done.
        log_q.delete();
        f = '0;
        f.mem_wen = 1'b1;
        f.r_wen   = 1'b1;
        run_instr(0, 0, f, 0, 1, 1, -1, h, a);
        check("store_err_cause", 64'(last_cause()), 64'd7);
        check("store_err_r_wen", 64'(count_field(0)), 64'd0);
        check("store_err_pc_en", 64'(count_field(1)), 64'd0);

        // Fetch timeout.
        log_q.delete();
        run_instr(99, 0, '0, 0, 0, 0, -1, h, a);
        check("fetch_to_cycles", 64'(count_field(6)), 64'd5);
        check("fetch_to_cause", 64'(last_cause()), 64'd1);
        check("fetch_to_next", 64'(state), 64'd1);

        // ebreak -> HALT.
        f = '0;
        f.ebreak  = 1'b1;
        f.mem_ren = 1'b1;
        run_instr(0, 0, f, 0, 0, 0, -1, h, a);
        check("ebreak_halts", 64'(h), 64'd1);
        log_q.delete();
`ifdef CTRL_PERF_CNT_EN
        c0 = cycle_cnt;
`endif
        halt_cycles(100);
        check("halt_ifu_req", 64'(count_field(4)), 64'd0);
        check("halt_cycles", 64'(count_field(5)), 64'd100);
`ifdef CTRL_PERF_CNT_EN
        check("halt_cycle_cnt", cycle_cnt - c0, 64'd100);
`endif
        reset_now();

        // Reset in the middle of an LSU wait.
        idle_cycle();
        f = '0;
        f.mem_ren = 1'b1;
        run_instr(0, 0, f, 99, 0, 0, 2, h, a);
        chk_en = 1'b0;
        #2;
        check("mid_mem_state", 64'(state), 64'd4);
        check("mid_mem_lsu_req", 64'(lsu_req), 64'd1);
        reset_now();
        idle_cycle();

        // Randomised instruction stream.
        for (int n = 0; n < 400; n++) begin
            f  = noise();
            f.ebreak = ($urandom_range(0, 24) == 0);
            fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            mk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
            run_instr(fk, ($urandom_range(0, 7) == 0), f, mk, ($urandom_range(0, 5) == 0),
                      1'($urandom), -1, h, a);
            if (h) begin
                halt_cycles(int'($urandom_range(1, 5)));
                reset_now();
                idle_cycle();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
